cordic_engine: RTL and testbench

- Parametrised, iterative, single-channel CORDIC core; successor to the fixed 16-entry arctangent table.
- Generates its arctangent constants internally for any ITERS and performs one micro-rotation per clock.
- Supports rotation mode (drive z to 0) and vectoring mode (drive y to 0), with quadrant pre-rotation so the full ±180° range converges.
- Sits between the angle/phase datapath and downstream consumers, with valid/ready handshakes on both sides.

---
 rtl/cordic_engine.sv | 140 ++++++++++++++
 tb/tb_cordic_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_engine.sv
// Iterative single-channel CORDIC: quadrant pre-rotation at accept, then one
// micro-rotation per clock in rotation (z -> 0) or vectoring (y -> 0) mode.
module cordic_engine #(
    parameter int WIDTH = 16,
    parameter int ITERS = 16,
    parameter int ZW    = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [ZW-1:0]    in_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH+1:0] out_x,
    output logic signed [WIDTH+1:0] out_y,
    output logic signed [ZW-1:0]    out_z
);
    localparam int XW = WIDTH + 2;
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic signed [ZW-1:0] Q90  = ZW'(65536);
    localparam logic [CW-1:0]        LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic signed [XW-1:0] x, y, xe, ye, xp, yp, xs, ys, xn, yn;
    logic signed [ZW-1:0] z, zp, zn, g;
    logic                 mode, d;
    logic [CW-1:0]        i;

    // round(atan(2^-k) * 2^17 / pi); entries past 16 round to zero
    function automatic logic [16:0] gamma_val(input int k);
        case (k)
            0:       return 17'h08000;
            1:       return 17'h04B90;
            2:       return 17'h027ED;
            3:       return 17'h01444;
            4:       return 17'h00A2C;
            5:       return 17'h00517;
            6:       return 17'h0028C;
            7:       return 17'h00146;
            8:       return 17'h000A3;
            9:       return 17'h00051;
            10:      return 17'h00029;
            11:      return 17'h00014;
            12:      return 17'h0000A;
            13:      return 17'h00005;
            14:      return 17'h00003;
            15:      return 17'h00001;
            16:      return 17'h00001;
            default: return 17'h00000;
        endcase
    endfunction

    assign xe = {{2{in_x[WIDTH-1]}}, in_x};
    assign ye = {{2{in_y[WIDTH-1]}}, in_y};

    // Fold the operand into the right half-plane (+-90 deg) so the
    // micro-rotations, which cover about +-99.9 deg, can converge.
    always_comb begin
        xp = xe;
        yp = ye;
        zp = in_z;
        if (!in_mode) begin
            if (in_z > Q90) begin
                xp = -ye; yp = xe; zp = in_z - Q90;
            end else if (in_z < -Q90) begin
                xp = ye; yp = -xe; zp = in_z + Q90;
            end
        end else if (xe[XW-1]) begin
            if (!ye[XW-1]) begin
                xp = ye; yp = -xe; zp = in_z + Q90;
            end else begin
                xp = -ye; yp = xe; zp = in_z - Q90;
            end
        end
    end

    always_comb begin
        d  = mode ? y[XW-1] : !z[ZW-1];
        xs = x >>> i;
        ys = y >>> i;
        g  = ZW'(gamma_val(int'(i)));
        xn = d ? x - ys : x + ys;
        yn = d ? y + xs : y - xs;
        zn = d ? z - g  : z + g;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (i == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            z    <= '0;
            i    <= '0;
            mode <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x    <= xp;
                    y    <= yp;
                    z    <= zp;
                    mode <= in_mode;
                    i    <= '0;
                end
                RUN: begin
                    x <= xn;
                    y <= yn;
                    z <= zn;
                    i <= i + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_x = x;
    assign out_y = y;
    assign out_z = z;
endmodule

// File: tb/tb_cordic_engine.sv
// Directed bench for cordic_engine: stimulus queues expected results, a forked
// monitor pops and compares them whenever a result is handed off.
module tb_cordic_engine;
    localparam int W  = 16;
    localparam int IT = 16;
    localparam int ZW = 18;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
    logic signed [W-1:0]  in_x = '0, in_y = '0;
    logic signed [ZW-1:0] in_z = '0;
    logic                 in_ready, out_valid;
    logic signed [W+1:0]  out_x, out_y;
    logic signed [ZW-1:0] out_z;

    logic                 s_in_valid = 1'b0, s_in_mode = 1'b0, s_out_ready = 1'b1;
    logic signed [11:0]   s_in_x = '0, s_in_y = '0;
    logic signed [ZW-1:0] s_in_z = '0;
    logic                 s_in_ready, s_out_valid;
    logic signed [13:0]   s_out_x, s_out_y;
    logic signed [ZW-1:0] s_out_z;

    cordic_engine #(.WIDTH(W), .ITERS(IT), .ZW(ZW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z));

    cordic_engine #(.WIDTH(12), .ITERS(8), .ZW(ZW)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_mode(s_in_mode), .in_x(s_in_x), .in_y(s_in_y), .in_z(s_in_z),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_x(s_out_x), .out_y(s_out_y), .out_z(s_out_z));

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    ex, ey, ez, txy, tz;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp, input int tol);
        int diff;
        n_chk++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    // angle compare is modulo 2^ZW so +180 and -180 deg are the same point
    task automatic chkz(input string nm, input int act, input int exp, input int tol);
        logic signed [ZW-1:0] dz;
        int diff;
        n_chk++;
        dz   = ZW'(act - exp);
        diff = int'(dz);
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d, mod 2^%0d)", nm, act, exp, tol, ZW);
        end
    endtask

    function automatic int gam(input int k);
        real r;
        r = $atan(1.0 / (2.0 ** k)) * 131072.0 / 3.14159265358979;
        return $rtoi(r + 0.5);
    endfunction

    // With x = y = 0 only the angle recurrence moves, so out_z is exact.
    function automatic int zmodel(input int zin);
        logic signed [ZW-1:0] zz;
        zz = ZW'(zin);
        if (zz > 18'sh10000)       zz = zz - 18'sh10000;
        else if (zz < -18'sh10000) zz = zz + 18'sh10000;
        for (int k = 0; k < IT; k++) begin
            if (!zz[ZW-1]) zz = zz - ZW'(gam(k));
            else           zz = zz + ZW'(gam(k));
        end
        return int'(zz);
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: got x=%0d y=%0d z=%0d expected none",
                             out_x, out_y, out_z);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_x"}, int'(out_x), e.ex, e.txy);
                    chk({e.name, "_y"}, int'(out_y), e.ey, e.txy);
                    chkz({e.name, "_z"}, int'(out_z), e.ez, e.tz);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand from IDLE and wait (bounded) until the result is up.
    task automatic issue(input string nm, input logic md, input int x, input int y, input int z,
                         input int ex, input int ey, input int ez, input int txy, input int tz);
        int lat;
        bit ir_ok;
        exp_t e;
        e.name = nm; e.ex = ex; e.ey = ey; e.ez = ez; e.txy = txy; e.tz = tz;
        q.push_back(e);
        in_mode  = md;
        in_x     = W'(x);
        in_y     = W'(y);
        in_z     = ZW'(z);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_x     = 16'sh7FFF;
        in_mode  = ~md;
        lat      = 1;
        ir_ok    = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) ir_ok = 1'b0;
            step();
            lat++;
        end
        chk({nm, "_latency"}, lat, IT + 1, 0);
        chk({nm, "_in_ready_low"}, int'(ir_ok), 1, 0);
    endtask

    task automatic op(input string nm, input logic md, input int x, input int y, input int z,
                      input int ex, input int ey, input int ez, input int txy, input int tz);
        issue(nm, md, x, y, z, ex, ey, ez, txy, tz);
        step();
    endtask

    initial begin
        int cx, cy, cz, lat;
        bit stable;
        int zv[6];

        fork
            monitor();
        join_none

        repeat (3) step();
        chk("reset_out_valid", int'(out_valid), 0, 0);
        chk("reset_in_ready", int'(in_ready), 1, 0);
        chk("reset_out_x", int'(out_x), 0, 0);
        chk("reset_out_y", int'(out_y), 0, 0);
        chk("reset_out_z", int'(out_z), 0, 0);
        rst_n = 1'b1;
        step();

        op("rot_0deg",    1'b0, 10000, 0, 0,          16468, 0,     0, 16, 16);
        op("rot_45deg",   1'b0, 10000, 0, 'h08000,    11644, 11644, 0, 16, 16);
        op("rot_135deg",  1'b0, 10000, 0, 'h18000,   -11644, 11644, 0, 16, 16);
        op("rot_m135deg", 1'b0, 10000, 0, -'h18000,  -11644, -11644, 0, 16, 16);
        op("vec_q3",      1'b1, -10000, -1000, 0,     16550, 0, -126914, 16, 32);
        op("vec_3_4",     1'b1, 3000, 4000, 0,        8234,  0, 38688,   16, 32);
        op("vec_180wrap", 1'b1, -10000, 0, 0,         16468, 0, -131072, 16, 32);

        zv = '{0, 'h10000, -'h10000, 'h1F000, -'h1FFFF, 'h05000};
        foreach (zv[k])
            op($sformatf("zpath_%0d", k), 1'b0, 0, 0, zv[k], 0, 0, zmodel(zv[k]), 0, 0);

        // backpressure: result must hold and stray inputs must be ignored
        out_ready = 1'b0;
        issue("bp_hold", 1'b0, 0, 10000, 0, 0, 16468, 0, 16, 16);
        cx = int'(out_x); cy = int'(out_y); cz = int'(out_z);
        stable = 1'b1;
        in_mode = 1'b0; in_x = 16'sd5000; in_y = 16'sd5000; in_z = 18'sh08000;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            step();
            if (!out_valid || in_ready || int'(out_x) != cx || int'(out_y) != cy || int'(out_z) != cz)
                stable = 1'b0;
        end
        chk("bp_stable", int'(stable), 1, 0);
        out_ready = 1'b1;
        in_mode = 1'b0; in_x = 16'sd10000; in_y = 16'sd0; in_z = 18'sh08000;
        in_valid = 1'b1;
        q.push_back('{"bp_next", 11644, 11644, 0, 16, 16});
        step();
        chk("bp_release_out_valid", int'(out_valid), 0, 0);
        chk("bp_release_in_ready", int'(in_ready), 1, 0);
        step();
        in_valid = 1'b0;
        chk("bp_next_accepted", int'(in_ready), 0, 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("bp_next_latency", lat, IT, 0);
        step();

        // reset in the middle of RUN discards the operand
        in_mode = 1'b0; in_x = 16'sd10000; in_y = 16'sd0; in_z = 18'sh08000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        chk("midrst_out_valid", int'(out_valid), 0, 0);
        chk("midrst_in_ready", int'(in_ready), 1, 0);
        chk("midrst_out_x", int'(out_x), 0, 0);
        chk("midrst_out_y", int'(out_y), 0, 0);
        chk("midrst_out_z", int'(out_z), 0, 0);
        rst_n = 1'b1;
        repeat (2) step();
        op("after_reset", 1'b0, 10000, 0, 'h08000, 11644, 11644, 0, 16, 16);

        // short engine: 8 iterations, 12-bit operands
        s_in_mode = 1'b0; s_in_x = 12'sd1000; s_in_y = 12'sd0; s_in_z = 18'sh08000;
        s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("it8_latency", lat, 9, 0);
        chk("it8_x", int'(s_out_x), 1164, 24);
        chk("it8_y", int'(s_out_y), 1164, 24);
        step();

        repeat (5) step();
        chk("queue_drained", q.size(), 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
